// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared pipeline constants for the ID-stage load hazard scoreboard.
// Also provides the x0 test used by every register-index check.
package load_hazard_scoreboard_pkg;

   localparam int REG_AW = 5;
   localparam int NREGS  = 32;
   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   function automatic logic is_x0(input logic [REG_AW-1:0] idx);
      return (idx == REG_X0);
   endfunction

endpackage

// File: rtl/load_hazard_scoreboard_bits.sv
// Per-register pending-load flags: one set port, two clear ports, two read ports.
// x0 is hard-wired to not pending.
module load_hazard_scoreboard_bits
   import load_hazard_scoreboard_pkg::*;
(
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              set_i,
   input  logic [REG_AW-1:0] set_idx_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] clr_idx_i,
   input  logic              clr2_i,
   input  logic [REG_AW-1:0] clr2_idx_i,
   input  logic [REG_AW-1:0] rd_a_idx_i,
   output logic              rd_a_o,
   input  logic [REG_AW-1:0] rd_b_idx_i,
   output logic              rd_b_o,
   output logic [NREGS-1:0]  pending_o
);

   logic [NREGS-1:0] pending_d;
   logic [NREGS-1:0] pending_q;

   // Next-state flags; a set wins over a clear on the same register.
   always_comb begin
      pending_d = pending_q;
      for (int i = 1; i < NREGS; i++) begin
         if (set_i && (set_idx_i == i[REG_AW-1:0])) begin
            pending_d[i] = 1'b1;
         end else if ((clr_i && (clr_idx_i == i[REG_AW-1:0])) ||
                      (clr2_i && (clr2_idx_i == i[REG_AW-1:0]))) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_q[i];
         end
      end
      pending_d[0] = 1'b0;
   end

   // Pending flag storage.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         pending_q <= {NREGS{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   assign rd_a_o    = pending_q[rd_a_idx_i];
   assign rd_b_o    = pending_q[rd_b_idx_i];
   assign pending_o = pending_q;

endmodule

// File: rtl/load_hazard_scoreboard.sv
// ID-stage load-use / WAW / capacity hazard detector with in-flight load tracking.
// Hazards look only at registered state; a same-cycle load return is not bypassed.
module load_hazard_scoreboard
   import load_hazard_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_W           = 2
)(
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_uses_rs1_i,
   input  logic              id_uses_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   input  logic              mem_done_i,
   input  logic [REG_AW-1:0] mem_done_rd_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              idex_bubble_o,
   output logic [CNT_W-1:0]  outstanding_o,
   output logic              err_o
);

   logic [NREGS-1:0]  pending_s;
   logic              rs1_pend_s;
   logic              rs2_pend_s;
   logic              ld_s;
   logic              raw_s;
   logic              waw_s;
   logic              cap_s;
   logic              stall_s;
   logic              issue_s;
   logic              cmp_req_s;
   logic              cmp_ok_s;
   logic              cmp_bad_s;
   logic              fl_clr_s;
   logic              fl_dec_s;
   logic              underflow_s;
   logic [CNT_W:0]    cnt_up_s;
   logic [CNT_W:0]    dec_s;

   logic [CNT_W-1:0]  outstanding_d, outstanding_q;
   logic              err_d, err_q;
   logic              ex_load_vld_d, ex_load_vld_q;
   logic [REG_AW-1:0] ex_load_rd_d, ex_load_rd_q;

   load_hazard_scoreboard_bits u_bits (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .set_i      (issue_s),
      .set_idx_i  (id_rd_i),
      .clr_i      (cmp_ok_s),
      .clr_idx_i  (mem_done_rd_i),
      .clr2_i     (fl_clr_s),
      .clr2_idx_i (ex_load_rd_q),
      .rd_a_idx_i (id_rs1_i),
      .rd_a_o     (rs1_pend_s),
      .rd_b_idx_i (id_rs2_i),
      .rd_b_o     (rs2_pend_s),
      .pending_o  (pending_s)
   );

   assign ld_s  = id_memread_i & id_regwrite_i & ~is_x0(id_rd_i);
   assign raw_s = id_valid_i & ((id_uses_rs1_i & ~is_x0(id_rs1_i) & rs1_pend_s) |
                                (id_uses_rs2_i & ~is_x0(id_rs2_i) & rs2_pend_s));
   assign waw_s = id_valid_i & ld_s & pending_s[id_rd_i];
   assign cap_s = id_valid_i & ld_s & (outstanding_q == CNT_W'(MAX_OUTSTANDING));

   // Reset forces the pipeline-control outputs to their run values.
   assign stall_s       = (raw_s | waw_s | cap_s) & ~flush_i & ~arst_i;
   assign pc_write_o    = ~stall_s;
   assign ifid_write_o  = ~stall_s;
   assign idex_bubble_o = (stall_s | flush_i) & ~arst_i;

   assign issue_s   = id_valid_i & ld_s & ~stall_s & ~flush_i;
   assign cmp_req_s = mem_done_i & ~is_x0(mem_done_rd_i);
   assign cmp_ok_s  = cmp_req_s & pending_s[mem_done_rd_i];
   assign cmp_bad_s = cmp_req_s & ~pending_s[mem_done_rd_i];
   assign fl_clr_s  = flush_i & ex_load_vld_q & pending_s[ex_load_rd_q];
   // A squashed load that also returns this cycle is only retired once.
   assign fl_dec_s  = fl_clr_s & ~(cmp_ok_s & (mem_done_rd_i == ex_load_rd_q));

   // Outstanding-count and error next state; the counter saturates at zero.
   always_comb begin
      cnt_up_s = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, issue_s};
      dec_s    = {{CNT_W{1'b0}}, cmp_ok_s} + {{CNT_W{1'b0}}, fl_dec_s};
      if (dec_s > cnt_up_s) begin
         outstanding_d = {CNT_W{1'b0}};
         underflow_s   = 1'b1;
      end else begin
         outstanding_d = CNT_W'(cnt_up_s - dec_s);
         underflow_s   = 1'b0;
      end
      err_d         = err_q | cmp_bad_s | underflow_s;
      ex_load_vld_d = issue_s;
      if (issue_s) begin
         ex_load_rd_d = id_rd_i;
      end else begin
         ex_load_rd_d = ex_load_rd_q;
      end
   end

   // Tracking state registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         outstanding_q <= {CNT_W{1'b0}};
         err_q         <= 1'b0;
         ex_load_vld_q <= 1'b0;
         ex_load_rd_q  <= REG_X0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         ex_load_vld_q <= ex_load_vld_d;
         ex_load_rd_q  <= ex_load_rd_d;
      end
   end

   assign outstanding_o = outstanding_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Self-checking bench: a behavioural model pushes expected outputs per cycle,
// which are popped and compared against the DUT away from the clock edge.
module tb_load_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       arst;
   logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
   logic [4:0] id_rs1, id_rs2, id_rd, mem_done_rd;
   logic       flush, mem_done;
   logic       pc_write, ifid_write, idex_bubble, err;
   logic [1:0] outstanding;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic       pcw;
      logic       ifw;
      logic       bub;
      logic [1:0] outs;
      logic       err;
   } exp_t;
   exp_t exp_q[$];

   bit m_pend[32];
   int m_cnt;
   bit m_exv;
   int m_exrd;
   bit m_err;

   always #5 clk = ~clk;

   load_hazard_scoreboard dut (
      .clk_i(clk), .arst_i(arst),
      .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
      .flush_i(flush), .mem_done_i(mem_done), .mem_done_rd_i(mem_done_rd),
      .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_bubble_o(idex_bubble),
      .outstanding_o(outstanding), .err_o(err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ld();
      return id_memread && id_regwrite && (id_rd != 5'd0);
   endfunction

   function automatic bit m_stall();
      bit hz;
      hz = id_valid && ((id_uses_rs1 && id_rs1 != 5'd0 && m_pend[id_rs1]) ||
                        (id_uses_rs2 && id_rs2 != 5'd0 && m_pend[id_rs2]) ||
                        (m_ld() && m_pend[id_rd]) ||
                        (m_ld() && m_cnt == 2));
      return hz && !flush;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_cnt = 0; m_exv = 1'b0; m_exrd = 0; m_err = 1'b0;
   endtask

   task automatic model_update();
      bit iss, cok, fl;
      int dec, tmp;
      iss = id_valid && m_ld() && !m_stall() && !flush;
      cok = 1'b0;
      if (mem_done && mem_done_rd != 5'd0) begin
         if (m_pend[mem_done_rd]) cok = 1'b1;
         else m_err = 1'b1;
      end
      fl  = flush && m_exv && m_pend[m_exrd];
      dec = 0;
      if (cok) dec++;
      if (fl && !(cok && mem_done_rd == m_exrd)) dec++;
      if (cok) m_pend[mem_done_rd] = 1'b0;
      if (fl) m_pend[m_exrd] = 1'b0;
      if (iss) m_pend[id_rd] = 1'b1;
      tmp = m_cnt + (iss ? 1 : 0) - dec;
      if (tmp < 0) begin
         m_err = 1'b1;
         tmp = 0;
      end
      m_cnt = tmp;
      m_exv = iss;
      if (iss) m_exrd = int'(id_rd);
   endtask

   task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl,
                       input logic dn, input logic [4:0] drd, input string tag);
      exp_t e, got;
      @(negedge clk);
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
      mem_done = dn; mem_done_rd = drd;
      #1;
      e.pcw  = !m_stall();
      e.ifw  = !m_stall();
      e.bub  = m_stall() || flush;
      e.outs = 2'(m_cnt);
      e.err  = m_err;
      exp_q.push_back(e);
      got = exp_q.pop_front();
      check_eq({tag, "_pcw"}, {31'd0, pc_write}, {31'd0, got.pcw});
      check_eq({tag, "_ifw"}, {31'd0, ifid_write}, {31'd0, got.ifw});
      check_eq({tag, "_bub"}, {31'd0, idex_bubble}, {31'd0, got.bub});
      check_eq({tag, "_outs"}, {30'd0, outstanding}, {30'd0, got.outs});
      check_eq({tag, "_err"}, {31'd0, err}, {31'd0, got.err});
      @(posedge clk);
      model_update();
   endtask

   task automatic t_load(input logic [4:0] rd, input logic dn, input logic [4:0] drd, input string tag);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, 1'b1, 1'b0, dn, drd, tag);
   endtask

   task automatic t_alu(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic dn, input logic [4:0] drd, input string tag);
      step(1'b1, r1, r2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, dn, drd, tag);
   endtask

   task automatic t_nop(input logic fl, input logic dn, input logic [4:0] drd, input string tag);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, fl, dn, drd, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1;
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      id_rd = 5'd0; id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b1;
      mem_done = 1'b0; mem_done_rd = 5'd0;
      model_reset();
      #2;
      check_eq("rst_pcw", {31'd0, pc_write}, 32'd1);
      check_eq("rst_ifw", {31'd0, ifid_write}, 32'd1);
      check_eq("rst_bub", {31'd0, idex_bubble}, 32'd0);
      check_eq("rst_outs", {30'd0, outstanding}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      flush = 1'b0;
      @(negedge clk);
      arst = 1'b0;

      // 1/2: load-use stall until the cycle after the return
      t_load(5'd5, 1'b0, 5'd0, "t1_ld5");
      t_alu(5'd5, 5'd1, 5'd6, 1'b0, 5'd0, "t1_use_a");
      t_alu(5'd5, 5'd1, 5'd6, 1'b0, 5'd0, "t1_use_b");
      t_alu(5'd5, 5'd1, 5'd6, 1'b1, 5'd5, "t2_same_cyc");
      t_alu(5'd5, 5'd1, 5'd6, 1'b0, 5'd0, "t2_next");
      check_eq("t1_out_zero", {30'd0, outstanding}, 32'd0);
      step(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, "t1_rs2_free");

      // 3: capacity stall
      t_load(5'd3, 1'b0, 5'd0, "t3_ld3");
      t_load(5'd4, 1'b0, 5'd0, "t3_ld4");
      t_load(5'd7, 1'b0, 5'd0, "t3_ld7_cap");
      t_load(5'd7, 1'b1, 5'd3, "t3_ld7_done3");
      t_load(5'd7, 1'b0, 5'd0, "t3_ld7_go");
      t_nop(1'b0, 1'b0, 5'd0, "t3_idle");
      check_eq("t3_out_two", {30'd0, outstanding}, 32'd2);
      t_load(5'd4, 1'b0, 5'd0, "t3_waw4");
      t_nop(1'b0, 1'b1, 5'd4, "t3_done4");
      t_nop(1'b0, 1'b1, 5'd7, "t3_done7");

      // 4: flush squashes the load just issued
      t_load(5'd9, 1'b0, 5'd0, "t4_ld9");
      t_nop(1'b1, 1'b0, 5'd0, "t4_flush");
      t_alu(5'd9, 5'd9, 5'd2, 1'b0, 5'd0, "t4_rd9");
      check_eq("t4_out_zero", {30'd0, outstanding}, 32'd0);
      t_load(5'd10, 1'b0, 5'd0, "t4_ld10");
      t_nop(1'b1, 1'b1, 5'd10, "t4_flush_done10");
      t_nop(1'b0, 1'b0, 5'd0, "t4_after");
      check_eq("t4_no_err", {31'd0, err}, 32'd0);
      t_nop(1'b0, 1'b1, 5'd0, "t4_done_x0");

      // 5: spurious return, loads to x0
      t_nop(1'b0, 1'b1, 5'd12, "t5_bad12");
      t_load(5'd0, 1'b0, 5'd0, "t5_ldx0");
      t_alu(5'd0, 5'd0, 5'd1, 1'b0, 5'd0, "t5_rdx0");
      check_eq("t5_err_sticky", {31'd0, err}, 32'd1);

      // 6: async reset in the middle of a stall
      t_load(5'd5, 1'b0, 5'd0, "t6_ld5");
      t_alu(5'd5, 5'd0, 5'd8, 1'b0, 5'd0, "t6_stall");
      @(negedge clk);
      #2;
      arst = 1'b1;
      #1;
      check_eq("t6_pcw", {31'd0, pc_write}, 32'd1);
      check_eq("t6_bub", {31'd0, idex_bubble}, 32'd0);
      check_eq("t6_outs", {30'd0, outstanding}, 32'd0);
      check_eq("t6_err", {31'd0, err}, 32'd0);
      model_reset();
      @(negedge clk);
      arst = 1'b0;
      t_alu(5'd5, 5'd0, 5'd8, 1'b0, 5'd0, "t6_after");
      t_nop(1'b0, 1'b1, 5'd5, "t6_stale_done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
